// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: issues 16-lane blocks into the stage-0 FFT pipeline one
// frame at a time, tracks frames in flight against a credit limit, counts
// returning result blocks and flags source underruns and output timeouts.
module fft_frame_ctrl #(
   parameter int BLK_PER_FRAME = 32,
   parameter int MAX_INFLIGHT  = 2,
   parameter int TIMEOUT       = 255
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              src_valid,
   output logic                              src_ready,
   output logic                              din_valid,
   output logic [$clog2(BLK_PER_FRAME)-1:0]  blk_idx,
   input  logic                              out_valid,
   output logic                              frame_done,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
   output logic                              busy,
   output logic                              err_underrun,
   output logic                              err_timeout,
   input  logic                              err_clr
);

   localparam int BW = $clog2(BLK_PER_FRAME);
   localparam int IW = $clog2(MAX_INFLIGHT + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [BW-1:0] LAST_BLK = BW'(BLK_PER_FRAME - 1);

   typedef enum logic [1:0] {IDLE, FILL, ABORT} state_t;

   state_t          state;
   logic [BW-1:0]   out_cnt;
   logic [TW-1:0]   tmo_cnt;
   logic            can_start;
   logic            last_in;
   logic            ov_live;
   logic            last_out;
   logic            underrun;
   logic            tmo_hit;

   // Handshake and event decode; everything here is gated by rst so the
   // outputs drop the moment reset is asserted.
   always_comb begin
      can_start  = enable && src_valid && (inflight < IW'(MAX_INFLIGHT));
      src_ready  = !rst && (((state == IDLE) && can_start) || (state == FILL));
      din_valid  = src_valid && src_ready;
      last_in    = din_valid && (blk_idx == LAST_BLK);
      underrun   = !rst && (state == FILL) && !src_valid;
      // Result blocks with nothing outstanding are stray and ignored.
      ov_live    = !rst && out_valid && (inflight != '0);
      last_out   = ov_live && (out_cnt == LAST_BLK);
      frame_done = last_out;
      tmo_hit    = !rst && !out_valid && (inflight != '0) &&
                   (tmo_cnt == TW'(TIMEOUT - 1));
      busy       = (state != IDLE) || (inflight != '0);
   end

   // Issue-side FSM and block index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         blk_idx <= '0;
      end else begin
         if (underrun)       blk_idx <= '0;
         else if (din_valid) blk_idx <= last_in ? '0 : blk_idx + BW'(1);
         case (state)
            IDLE:    if (din_valid && !last_in) state <= FILL;
            FILL:    if (underrun) state <= ABORT;
                     else if (last_in) state <= IDLE;
            ABORT:   if (inflight == '0) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Frame credit and output block counter. A frame counts as in flight only
   // once its last block has issued; a timeout abandons everything outstanding.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight <= '0;
         out_cnt  <= '0;
      end else if (tmo_hit) begin
         inflight <= '0;
         out_cnt  <= '0;
      end else begin
         inflight <= inflight + IW'(last_in) - IW'(last_out);
         if (ov_live) out_cnt <= last_out ? '0 : out_cnt + BW'(1);
      end
   end

   // Idle-cycle counter while result blocks are owed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        tmo_cnt <= '0;
      else if (out_valid || inflight == '0 || tmo_hit) tmo_cnt <= '0;
      else                                            tmo_cnt <= tmo_cnt + TW'(1);
   end

   // Sticky error flags; a new error wins over a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_underrun <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         if (underrun)     err_underrun <= 1'b1;
         else if (err_clr) err_underrun <= 1'b0;
         if (tmo_hit)      err_timeout  <= 1'b1;
         else if (err_clr) err_timeout  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with default parameters (32 blocks per
// frame, 2 frames of credit, 255-cycle timeout).
module tb_fft_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst, enable, src_valid, out_valid, err_clr;
   logic       src_ready, din_valid, frame_done, busy, err_underrun, err_timeout;
   logic [4:0] blk_idx;
   logic [1:0] inflight;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   fft_frame_ctrl #(.BLK_PER_FRAME(32), .MAX_INFLIGHT(2), .TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .enable(enable), .src_valid(src_valid),
      .src_ready(src_ready), .din_valid(din_valid), .blk_idx(blk_idx),
      .out_valid(out_valid), .frame_done(frame_done), .inflight(inflight),
      .busy(busy), .err_underrun(err_underrun), .err_timeout(err_timeout),
      .err_clr(err_clr)
   );

   // Step to 1 time unit past the next rising edge (the drive point).
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   // Present n consecutive blocks, expecting indices first, first+1, ... mod 32.
   task automatic issue(input int n, input int first);
      src_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         #1;
         chk("issue_din_valid", 32'(din_valid), 1);
         chk("issue_blk_idx", 32'(blk_idx), (first + i) % 32);
         nxt();
      end
   endtask

   // Return n result blocks; frame_done expected only on pulse done_at.
   task automatic drain(input int n, input int done_at);
      for (int j = 0; j < n; j++) begin
         out_valid = 1'b1;
         #1;
         chk("drain_frame_done", 32'(frame_done), 32'(j == done_at));
         nxt();
      end
      out_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with every request input asserted: nothing may leak out.
      rst = 1'b1; enable = 1'b1; src_valid = 1'b1; out_valid = 1'b1; err_clr = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk("rst_src_ready", 32'(src_ready), 0);
      chk("rst_din_valid", 32'(din_valid), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_blk_idx", 32'(blk_idx), 0);
      chk("rst_inflight", 32'(inflight), 0);
      chk("rst_err_underrun", 32'(err_underrun), 0);
      chk("rst_err_timeout", 32'(err_timeout), 0);
      src_valid = 1'b0; out_valid = 1'b0; rst = 1'b0;
      nxt();

      // Single frame: 32 blocks, then 32 results after 10 idle cycles.
      issue(32, 0);
      src_valid = 1'b0;
      #1;
      chk("single_inflight", 32'(inflight), 1);
      chk("single_din_idle", 32'(din_valid), 0);
      chk("single_busy", 32'(busy), 1);
      repeat (10) nxt();
      drain(32, 31);
      #1;
      chk("single_inflight_end", 32'(inflight), 0);
      chk("single_busy_end", 32'(busy), 0);
      nxt();

      // Credit limit: two frames back to back, then the source is held off.
      issue(64, 0);
      #1;
      chk("credit_src_ready", 32'(src_ready), 0);
      chk("credit_din_valid", 32'(din_valid), 0);
      chk("credit_inflight", 32'(inflight), 2);
      nxt();
      #1;
      chk("credit_hold", 32'(src_ready), 0);
      nxt();
      for (int j = 0; j < 32; j++) begin
         out_valid = 1'b1;
         #1;
         chk("credit_ready_blocked", 32'(src_ready), 0);
         chk("credit_frame_done", 32'(frame_done), 32'(j == 31));
         nxt();
      end
      out_valid = 1'b0;
      #1;
      chk("reopen_src_ready", 32'(src_ready), 1);
      chk("reopen_inflight", 32'(inflight), 1);
      chk("reopen_blk_idx", 32'(blk_idx), 0);

      // Frame 3 issues while frame 2 returns; last block and last result coincide.
      for (int k = 0; k < 32; k++) begin
         out_valid = 1'b1;
         #1;
         chk("overlap_blk_idx", 32'(blk_idx), k);
         chk("overlap_inflight", 32'(inflight), 1);
         chk("overlap_frame_done", 32'(frame_done), 32'(k == 31));
         nxt();
      end
      out_valid = 1'b0;

      // Frame 4 starts immediately, then the source stalls at block 17.
      #1;
      chk("b2b_inflight", 32'(inflight), 1);
      chk("b2b_din_valid", 32'(din_valid), 1);
      chk("b2b_blk_idx", 32'(blk_idx), 0);
      nxt();
      issue(16, 1);
      src_valid = 1'b0;
      #1;
      chk("underrun_blk_idx", 32'(blk_idx), 17);
      chk("underrun_din_valid", 32'(din_valid), 0);
      nxt();
      src_valid = 1'b1;
      #1;
      chk("underrun_flag", 32'(err_underrun), 1);
      chk("underrun_blk_zero", 32'(blk_idx), 0);
      chk("underrun_inflight", 32'(inflight), 1);
      chk("abort_src_ready", 32'(src_ready), 0);
      chk("abort_busy", 32'(busy), 1);
      src_valid = 1'b0;
      nxt();
      drain(32, 31);
      src_valid = 1'b1;
      #1;
      chk("abort_drained_inflight", 32'(inflight), 0);
      chk("abort_last_cycle_ready", 32'(src_ready), 0);
      nxt();

      // Restart from block 0, then clear and a new underrun in the same cycle.
      issue(5, 0);
      src_valid = 1'b0;
      err_clr = 1'b1;
      #1;
      chk("clr_vs_set_blk_idx", 32'(blk_idx), 5);
      nxt();
      err_clr = 1'b0;
      #1;
      chk("clr_vs_set_underrun", 32'(err_underrun), 1);
      nxt();
      err_clr = 1'b1;
      nxt();
      err_clr = 1'b0;
      #1;
      chk("clr_underrun", 32'(err_underrun), 0);
      chk("clr_busy", 32'(busy), 0);
      nxt();

      // Timeout: one frame outstanding, no results for 255 cycles.
      issue(32, 0);
      src_valid = 1'b0;
      repeat (254) nxt();
      #1;
      chk("tmo_before_flag", 32'(err_timeout), 0);
      chk("tmo_before_inflight", 32'(inflight), 1);
      nxt();
      chk("tmo_flag", 32'(err_timeout), 1);
      chk("tmo_inflight", 32'(inflight), 0);
      chk("tmo_no_done", 32'(frame_done), 0);
      err_clr = 1'b1;
      nxt();
      err_clr = 1'b0;
      #1;
      chk("tmo_clr", 32'(err_timeout), 0);
      nxt();

      // Stray results with nothing outstanding must not advance the counter.
      out_valid = 1'b1;
      repeat (3) begin
         #1;
         chk("stray_frame_done", 32'(frame_done), 0);
         chk("stray_inflight", 32'(inflight), 0);
         nxt();
      end
      out_valid = 1'b0;
      issue(32, 0);
      src_valid = 1'b0;
      drain(32, 31);
      #1;
      chk("stray_after_inflight", 32'(inflight), 0);
      nxt();

      // Asynchronous reset mid-frame with a frame in flight.
      issue(32, 0);
      issue(9, 0);
      #1;
      chk("arst_pre_blk_idx", 32'(blk_idx), 9);
      chk("arst_pre_inflight", 32'(inflight), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_blk_idx", 32'(blk_idx), 0);
      chk("arst_inflight", 32'(inflight), 0);
      chk("arst_src_ready", 32'(src_ready), 0);
      chk("arst_din_valid", 32'(din_valid), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_frame_done", 32'(frame_done), 0);
      src_valid = 1'b0;
      nxt();
      rst = 1'b0;
      nxt();
      issue(32, 0);
      src_valid = 1'b0;
      #1;
      chk("post_rst_inflight", 32'(inflight), 1);
      nxt();
      drain(32, 31);
      #1;
      chk("post_rst_inflight_end", 32'(inflight), 0);
      chk("post_rst_busy", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter BLK_PER_FRAME, default 32, meaning 16-lane input blocks per 512-point frame.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2, meaning frames issued to the stage-0 pipeline but not yet fully returned.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning idle cycles allowed while outputs are outstanding.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port enable, input, 1 bit: permits new frames to start.
REQ-007 SHALL have port src_valid, input, 1 bit: the source presents a 16-lane block.
REQ-008 SHALL have port src_ready, output, 1 bit: the controller accepts the block this cycle.
REQ-009 SHALL have port din_valid, output, 1 bit: drives the stage-0 pipeline input valid.
REQ-010 SHALL have port blk_idx, output, clog2(BLK_PER_FRAME) bits: index of the block issued this cycle.
REQ-011 SHALL have port out_valid, input, 1 bit: pipeline output valid (stage-0/CBFP result block).
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame's last output block returns.
REQ-013 SHALL have port inflight, output, clog2(MAX_INFLIGHT+1) bits: current outstanding frame count.
REQ-014 SHALL have port busy, output, 1 bit: the FSM is not IDLE, or inflight != 0.
REQ-015 SHALL have port err_underrun, output, 1 bit: sticky flag; the source stalled mid-frame.
REQ-016 SHALL have port err_timeout, output, 1 bit: sticky flag; outputs stopped while frames were outstanding.
REQ-017 SHALL have port err_clr, input, 1 bit: clears both sticky error flags.

Function
REQ-018 SHALL implement FSM states IDLE, FILL, ABORT.
REQ-019 IDLE -> FILL SHALL occur when enable=1, src_valid=1 and inflight<MAX_INFLIGHT; that cycle issues block 0.
REQ-020 src_ready SHALL be combinational:
- 1 in IDLE when the IDLE->FILL condition holds;
- 1 throughout FILL;
- 0 otherwise.
REQ-021 din_valid SHALL equal src_valid & src_ready (combinational, no added latency).
REQ-022 blk_idx SHALL increment on every din_valid and wrap to 0 after BLK_PER_FRAME-1.
REQ-023 The block with blk_idx=BLK_PER_FRAME-1 SHALL return the FSM to IDLE on the next edge and increment the issue count.
REQ-024 Back-to-back frames SHALL be allowed: a frame may start in the cycle immediately after a last block if the credit condition holds.
REQ-025 In FILL, src_valid=0 SHALL set err_underrun, move the FSM to ABORT and zero blk_idx.
- The partial frame SHALL NOT count as inflight.
REQ-026 ABORT SHALL hold src_ready=0 until inflight=0, then go to IDLE.
REQ-027 Output counter SHALL count out_valid pulses.
- At BLK_PER_FRAME-1 plus out_valid: pulse frame_done for one cycle, decrement inflight, wrap the counter to 0.
REQ-028 A frame start and a frame_done in the same cycle SHALL leave inflight unchanged.
REQ-029 out_valid while inflight=0 SHALL be ignored.
REQ-030 Timeout counter SHALL:
- reset to 0 on any out_valid, or when inflight=0;
- otherwise increment when inflight>0;
- on reaching TIMEOUT: set err_timeout, force inflight and the output counter to 0, and pulse nothing.
REQ-031 err_clr SHALL clear both flags.
- A simultaneous set condition SHALL take priority (the flag stays 1).
REQ-032 enable=0 SHALL NOT interrupt a frame already in FILL.

Reset
REQ-033 While rst=1 the block SHALL hold:
- FSM in IDLE;
- blk_idx=0, output counter=0, inflight=0, timeout counter=0;
- src_ready=0, din_valid=0, frame_done=0, busy=0, err_underrun=0, err_timeout=0.
REQ-034 Assertion of rst mid-frame SHALL discard all frame and credit state immediately, without waiting for a clock edge.

Verification
REQ-035 Single frame: enable=1, src_valid held 32 cycles, then 32 out_valid pulses after 10 cycles.
- Expect din_valid for 32 cycles, blk_idx 0..31, inflight 1.
- Expect frame_done exactly once, on the 32nd out_valid; inflight returns to 0.
REQ-036 Credit limit: src_valid held continuously with out_valid=0.
- Expect 64 din_valid cycles, then src_ready=0 with inflight=2.
- The first 32 out_valid pulses reopen src_ready on the following cycle.
REQ-037 Underrun: src_valid drops at blk_idx=17.
- Expect err_underrun=1, blk_idx=0, inflight unchanged.
- The next frame restarts at blk_idx=0.
REQ-038 Simultaneous events:
- last output block and a new frame start in the same cycle -> frame_done=1, inflight constant;
- err_clr together with a new underrun -> err_underrun stays 1.
REQ-039 Timeout (TIMEOUT=255): inflight=1 and no out_valid for 255 cycles.
- Expect err_timeout=1 and inflight=0.
- err_clr clears the flag on the next cycle.
REQ-040 Async reset: assert rst at blk_idx=9 between clock edges.
- All outputs reach their reset values immediately.
- After release, a full frame completes normally.
